// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants, FSM state type and kernel weights for the
// binary-pixel 3x3 convolution accumulator.
//   ACC_W     : accumulator width (signed two's complement)
//   state_e   : window-processing FSM states
//   W         : 3x3 kernel weights, row-major p0..p8
//   weight_ext: weight k sign-extended to accumulator width
package cnn_pkg;

  localparam int unsigned ACC_W     = 12;
  localparam int unsigned OUT_W     = 8;
  localparam int unsigned PIX_N     = 9;
  localparam int unsigned PIX_CNT_W = 4;
  localparam int unsigned WIN_CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    POST = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam logic signed [7:0] W [0:8] = '{
    8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64,
    -8'sd64, -8'sd64, -8'sd64, -8'sd64
  };

  function automatic logic [ACC_W-1:0] weight_ext(input logic [PIX_CNT_W-1:0] k);
    logic [7:0] w;
    w = W[k];
    return {{(ACC_W-8){w[7]}}, w};
  endfunction

endpackage

// File: rtl/conv_sat.sv
// conv_sat: combinational output mapping of the post-bias window sum.
//   val_i : signed ACC_W-bit post-bias sum
//   res_c : OUT_W-bit result byte
// Build option CONV_RELU_EN: clamp to unsigned 0..255 (ReLU).
// Default (macro undefined): saturate to signed -128..127, two's complement.
module conv_sat
  import cnn_pkg::*;
(
  input  logic [ACC_W-1:0] val_i,
  output logic [OUT_W-1:0] res_c
);

  logic signed [ACC_W-1:0] val_s;
  assign val_s = signed'(val_i);

`ifdef CONV_RELU_EN
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(0);
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(255);

  always_comb begin
    res_c = val_i[OUT_W-1:0];
    if (val_s < LO) begin
      res_c = '0;
    end else if (val_s > HI) begin
      res_c = 8'hFF;
    end
  end
`else
  localparam logic signed [ACC_W-1:0] LO = -ACC_W'(128);
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(127);

  always_comb begin
    res_c = val_i[OUT_W-1:0];
    if (val_s < LO) begin
      res_c = 8'h80;
    end else if (val_s > HI) begin
      res_c = 8'h7F;
    end
  end
`endif

endmodule

// File: rtl/conv3x3_accum.sv
// conv3x3_accum: accumulates one 3x3 window of binary pixels (p0..p8, one per
// cycle) against fixed kernel weights, adds BIAS, maps the sum to a byte and
// presents it on a valid/ready output. Counts accepted windows per frame.
//   clk, rst (sync, active-high)
//   strt, din        : window start strobe and serial pixel input
//   bsy              : window in flight or result pending
//   dout, dout_vld   : result byte and its valid, held until dout_rdy
//   dout_rdy         : downstream ready
//   frm_done         : one-cycle pulse after the last window of a frame is taken
// Build option CONV_RELU_EN selects ReLU clamping in conv_sat.
module conv3x3_accum
  import cnn_pkg::*;
#(
  parameter int unsigned       NUM_WIN = 676,
  parameter logic signed [7:0] BIAS    = 8'sd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt,
  input  logic             din,
  output logic             bsy,
  output logic [OUT_W-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             frm_done
);

  state_e                 state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [WIN_CNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic [OUT_W-1:0]       dout_q, dout_d;
  logic                   dout_vld_q, dout_vld_d;
  logic                   frm_done_q, frm_done_d;
  logic                   bsy_q, bsy_d;

  logic [ACC_W-1:0]       post_sum;
  logic [OUT_W-1:0]       sat_c;

  assign post_sum = acc_q + {{(ACC_W-8){BIAS[7]}}, BIAS};

  conv_sat u_sat (
    .val_i (post_sum),
    .res_c (sat_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    pix_cnt_d  = pix_cnt_q;
    win_cnt_d  = win_cnt_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    frm_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // p0 is on din in the strt cycle itself
        if (strt) begin
          acc_d     = din ? weight_ext(PIX_CNT_W'(0)) : '0;
          pix_cnt_d = PIX_CNT_W'(1);
          state_d   = ACC;
        end
      end
      ACC: begin
        if (din) begin
          acc_d = acc_q + weight_ext(pix_cnt_q);
        end
        if (pix_cnt_q == PIX_CNT_W'(PIX_N - 1)) begin
          pix_cnt_d = '0;
          state_d   = POST;
        end else begin
          pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
        end
      end
      POST: begin
        dout_d     = sat_c;
        dout_vld_d = 1'b1;
        state_d    = OUT;
      end
      OUT: begin
        if (dout_vld_q && dout_rdy) begin
          dout_vld_d = 1'b0;
          acc_d      = '0;
          state_d    = IDLE;
          if (win_cnt_q == WIN_CNT_W'(NUM_WIN - 1)) begin
            win_cnt_d  = '0;
            frm_done_d = 1'b1;
          end else begin
            win_cnt_d = win_cnt_q + WIN_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    bsy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      pix_cnt_q  <= '0;
      win_cnt_q  <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      frm_done_q <= 1'b0;
      bsy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pix_cnt_q  <= pix_cnt_d;
      win_cnt_q  <= win_cnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      frm_done_q <= frm_done_d;
      bsy_q      <= bsy_d;
    end
  end

  assign bsy      = bsy_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign frm_done = frm_done_q;

endmodule

// File: doc/conv3x3_accum.md
CONV3X3_ACCUM -- requirements
Module: conv3x3_accum

Interface
REQ-001 Parameter NUM_WIN, default 676, number of 3x3 windows per frame (26x26).
REQ-002 Parameter BIAS, default 0, signed 8-bit bias added to each window sum.
REQ-003 Port clk  input  1  single clock; all logic rising-edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port strt  input  1  first pixel of a window is on din this cycle.
REQ-006 Port din  input  1  binary pixel stream, one pixel per cycle, row-major window order p0..p8.
REQ-007 Port bsy  output  1  high while a window is being processed or its result is unconsumed.
REQ-008 Port dout  output  8  result byte.
REQ-009 Port dout_vld  output  1  dout valid.
REQ-010 Port dout_rdy  input  1  downstream accepts dout when dout_vld is high.
REQ-011 Port frm_done  output  1  one-cycle pulse after the last window result of a frame is accepted.

Function
REQ-012 The FSM SHALL have states IDLE, ACC, POST and OUT.
- IDLE->ACC on strt.
- ACC->POST after 9 pixels.
- POST->OUT unconditionally.
- OUT->IDLE on dout_vld && dout_rdy.
REQ-013 strt in IDLE SHALL capture din as p0 in that same cycle; p1..p8 SHALL be sampled on the 8 following consecutive cycles with no gaps.
REQ-014 The accumulator SHALL be 12-bit signed and SHALL add weight W[k] for each pixel pk==1; pixels equal to 0 add nothing.
REQ-015 POST SHALL add sign-extended BIAS, then apply the output mapping of REQ-025/026, and register the result into dout.
REQ-016 Latency: with strt at cycle 0, dout_vld SHALL rise at cycle 10.
REQ-017 dout and dout_vld SHALL hold stable until the handshake completes; a stalled dout_rdy SHALL stall indefinitely.
REQ-018 bsy SHALL be high in ACC, POST and OUT, and low only in IDLE.
REQ-019 strt while bsy is high SHALL be ignored and SHALL NOT disturb the accumulation in progress.
REQ-020 A 10-bit window counter SHALL increment on each accepted result.
- At NUM_WIN-1, it SHALL wrap to 0 on acceptance.
- frm_done SHALL pulse the cycle after that acceptance.
REQ-021 Back-to-back: strt is legal in the cycle after the OUT handshake (IDLE); the minimum window period is 11 cycles.

Reset
REQ-022 rst SHALL force, on the next clk edge regardless of state:
- state=IDLE, accumulator=0, pixel counter=0, window counter=0.
- dout=0, dout_vld=0, frm_done=0, bsy=0.
REQ-023 Reset mid-ACC or mid-OUT SHALL discard the partial or pending result; no dout_vld may follow the reset without a new strt.
REQ-024 rst SHALL take priority over strt and dout_rdy in the same cycle.

Configuration
REQ-025 With CONV_RELU_EN defined, the post-bias value SHALL be clamped to the unsigned range 0..255: negative becomes 0, values above 255 become 255.
REQ-026 Without CONV_RELU_EN, the post-bias value SHALL be saturated to signed -128..127 and output in two's complement.

Structure
REQ-027 Package cnn_pkg SHALL hold:
- ACC_W=12.
- The state enum typedef.
- Constant weight array W[0:8], signed 8-bit = {64,64,64,64,64,-64,-64,-64,-64}.
REQ-028 The output mapping of REQ-025/026 SHALL be a sub-module conv_sat: purely combinational, 12-bit in, 8-bit out.

Verification
REQ-029 Pixels 0,0,0,0,0,0,0,0,0, BIAS=0 -> dout=0x00 at cycle 10.
REQ-030 Pixels 1,1,1,1,1,0,0,0,0 (sum 320) -> dout=0xFF with CONV_RELU_EN; dout=0x7F without.
REQ-031 Pixels 0,0,0,0,0,1,1,1,1 (sum -256) -> dout=0x00 with CONV_RELU_EN; dout=0x80 without.
REQ-032 Pixels all 1 (sum 64), dout_rdy low for 20 cycles -> dout=0x40 held stable, bsy=1 throughout; strt pulses during the stall are ignored.
REQ-033 rst at cycle 4 of ACC, then a fresh all-ones window -> exactly one result, 0x40; no stale output.
REQ-034 676 back-to-back windows with dout_rdy=1 -> exactly one frm_done pulse, one cycle after the 676th acceptance; the window counter returns to 0.
